// File: rtl/alu_exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_pkg
// Description : Shared types for the ALU execution unit. Defines the opcode
//               encoding, the controller state encoding and the packed
//               flag-register layout.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_exec_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SHL = 3'b110,
    ALU_LDI = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } exec_state_e;

  // Bit order is {o, c, z, n}.
  typedef struct packed {
    logic o;
    logic c;
    logic z;
    logic n;
  } alu_flags_t;

endpackage : alu_exec_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Purely combinational ALU. Computes the result and the next
//               flag values for one operation.
// Ports       : a, b   - operands (WIDTH)
//               imm    - immediate, used by LDI (WIDTH)
//               op     - operation code (alu_op_e)
//               y      - result (WIDTH)
//               flags  - {o, c, z, n} for this result
// Macro       : ALU_SAT_EN - when defined, ADD/SUB saturate on signed
//               overflow instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] y,
  output alu_flags_t       flags
);

  localparam int SHW = $clog2(WIDTH);

`ifdef ALU_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;
  logic           add_ovf;
  logic           sub_ovf;
  logic           c_flag;
  logic           o_flag;

  always_comb begin
    // The extra top bit holds carry-out for ADD and borrow for SUB.
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} - {1'b0, b};
    // Signed overflow: result sign disagrees with what the operand signs allow.
    add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1]  != a[WIDTH-1]);
    sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);

    y      = '0;
    c_flag = 1'b0;
    o_flag = 1'b0;
    case (op)
      ALU_ADD: begin
        y      = sum_ext[WIDTH-1:0];
        c_flag = sum_ext[WIDTH];
        o_flag = add_ovf;
      end
      ALU_SUB: begin
        y      = diff_ext[WIDTH-1:0];
        c_flag = diff_ext[WIDTH];
        o_flag = sub_ovf;
      end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SHL: y = a << b[SHW-1:0];
      ALU_LDI: y = imm;
      default: y = '0;
    endcase

`ifdef ALU_SAT_EN
    // On overflow the true result's sign is that of operand a, so a
    // non-negative a overflowed upward and a negative a overflowed downward.
    if (((op == ALU_ADD) || (op == ALU_SUB)) && o_flag) begin
      y = a[WIDTH-1] ? SMIN : SMAX;
    end
`endif

    flags.o = o_flag;
    flags.c = c_flag;
    flags.z = (y == '0);
    flags.n = y[WIDTH-1];
  end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Register file, operand latches, ALU and flag register driven
//               by a valid/ready command interface. Each command walks
//               IDLE -> READ -> EXEC -> WB, one command per four cycles.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               cmd_valid/cmd_ready - command handshake
//               cmd_op/dst/srca/srcb/imm - command fields
//               done                - one-cycle pulse during writeback
//               result              - last written result
//               O, C, Z, N          - flag register
//               disp_reg            - contents of register DISP_IDX
// Macro       : ALU_SAT_EN - forwarded to alu_core (saturating ADD/SUB).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int NUM_REGS = 8,
  parameter  int DISP_IDX = 7,
  localparam int RW       = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [RW-1:0]    cmd_dst,
  input  logic [RW-1:0]    cmd_srca,
  input  logic [RW-1:0]    cmd_srcb,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             O,
  output logic             C,
  output logic             Z,
  output logic             N,
  output logic [WIDTH-1:0] disp_reg
);

  localparam logic [RW-1:0] DISP_SEL = RW'(DISP_IDX);

  exec_state_e      state;
  alu_op_e          op_r;
  logic [RW-1:0]    dst_r;
  logic [RW-1:0]    srca_r;
  logic [RW-1:0]    srcb_r;
  logic [WIDTH-1:0] imm_r;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] regs [NUM_REGS];
  alu_flags_t       flags_r;

  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic [WIDTH-1:0] alu_y;
  alu_flags_t       alu_flags;

  // R0 is hard-wired to zero on the read side; it is also never written.
  assign rd_a = (srca_r == '0) ? '0 : regs[srca_r];
  assign rd_b = (srcb_r == '0) ? '0 : regs[srcb_r];

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .a     (op_a),
    .b     (op_b),
    .imm   (imm_r),
    .op    (op_r),
    .y     (alu_y),
    .flags (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      result    <= '0;
      flags_r   <= '0;
      op_r      <= ALU_ADD;
      dst_r     <= '0;
      srca_r    <= '0;
      srcb_r    <= '0;
      imm_r     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_r      <= alu_op_e'(cmd_op);
            dst_r     <= cmd_dst;
            srca_r    <= cmd_srca;
            srcb_r    <= cmd_srcb;
            imm_r     <= cmd_imm;
            cmd_ready <= 1'b0;
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          op_a  <= rd_a;
          op_b  <= rd_b;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          // Result and flags become visible together with the done pulse.
          result  <= alu_y;
          flags_r <= alu_flags;
          done    <= 1'b1;
          state   <= ST_WB;
        end
        ST_WB: begin
          if (dst_r != '0) begin
            regs[dst_r] <= result;
          end
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign O        = flags_r.o;
  assign C        = flags_r.c;
  assign Z        = flags_r.z;
  assign N        = flags_r.n;
  assign disp_reg = regs[DISP_SEL];

endmodule : alu_exec_unit
`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor to the fixed 32-bit ALU datapath: register file, operand latches, ALU and flag register in one block, driven by a valid/ready command interface.
- Replaces the ad-hoc controller-to-operand-register wiring.
- Sits between the command decoder and the seven-segment display driver.
- Exposes one register file entry permanently for display.

Parameters:
- WIDTH, 32, datapath and register width in bits (≥4, power of two).
- NUM_REGS, 8, register file depth (power of two, ≥2); RW = $clog2(NUM_REGS).
- DISP_IDX, 7, register index mirrored on disp_reg.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  unit can accept a command.
- cmd_op  in  3  operation code.
- cmd_dst  in  RW  destination register.
- cmd_srca  in  RW  source A register.
- cmd_srcb  in  RW  source B register.
- cmd_imm  in  WIDTH  immediate for LDI.
- done  out  1  one-cycle pulse at writeback.
- result  out  WIDTH  last written result, held until next writeback.
- O, C, Z, N  out  1 each  flag register.
- disp_reg  out  WIDTH  current contents of register DISP_IDX.

Behaviour:
- Reset (synchronous, active-high, rst): state=IDLE; all registers, result, and flags cleared to 0; done=0; cmd_ready=1 on the next cycle.
- Reset mid-operation aborts the operation with no writeback.
- Op codes:
  - 000 ADD
  - 001 SUB (a−b)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT (signed a<b → 1, else 0)
  - 110 SHL (a << b[$clog2(WIDTH)-1:0])
  - 111 LDI (result=cmd_imm)
- R0 reads as zero. Writes to R0 are discarded, but flags and result still update.
- FSM: IDLE → READ → EXEC → WB → IDLE.
  - IDLE: cmd_ready=1. On cmd_valid && cmd_ready, latch op, dst, srca, srcb, and imm; go to READ.
  - READ: load operand registers op_a and op_b from the register file.
  - EXEC: compute the ALU result and next flags; register both.
  - WB: write reg[dst] (unless dst=0); update result and flags; done=1 for exactly this cycle.
- cmd_ready=0 in READ, EXEC, and WB. Commands offered then are not accepted and must be held by the sender.
- Latency: accept edge T → done high in cycle T+3. Maximum throughput is one command per 4 cycles.
- Operands are read in READ, so a command sourcing the previous command's dst sees the written value; no hazard exists.
- Flags:
  - Z = (result==0); N = result[WIDTH-1].
  - ADD: C=carry out; O=signed overflow.
  - SUB: C=borrow (unsigned a<b); O=signed overflow.
  - All other ops: C=0, O=0.
- Arithmetic wraps modulo 2^WIDTH.
- disp_reg is combinational from the register array and reflects a write in the cycle after WB.
- If srca, srcb, and dst are all the same register, the operation is still legal.

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined: ADD and SUB saturate to signed max (0x7FFF_FFFF) on positive overflow and signed min (0x8000_0000) on negative overflow. O still reports 1. C is computed from the unsaturated operation. Z and N follow the saturated result.
- Undefined: ADD and SUB wrap. No saturation logic is present.

Decomposition:
- Package alu_exec_pkg:
  - typedef enum logic [2:0] alu_op_e (ADD..LDI)
  - typedef enum logic [1:0] exec_state_e (IDLE, READ, EXEC, WB)
  - flags struct {O, C, Z, N}
- Sub-module alu_core (combinational), parametrised by WIDTH. Takes a, b, imm, op; returns y and flags. The ALU_SAT_EN logic lives there.
- FSM, register file, and operand latches live in alu_exec_unit.

Test Plan (WIDTH=32, NUM_REGS=8):
- Reset mid-EXEC of ADD R1 → rst high 1 cycle → no done; R1=0; all flags 0; cmd_ready=1 next cycle.
- LDI R1,5; LDI R2,3; SUB R3,R1,R2 → done 3 cycles after each accept; result=2; C=0, O=0, Z=0, N=0. Then SUB R4,R2,R1 → 0xFFFF_FFFE, C=1, N=1.
- LDI R1,0x7FFF_FFFF; LDI R2,1; ADD R7,R1,R2 → without ALU_SAT_EN: disp_reg=0x8000_0000, O=1, N=1. With ALU_SAT_EN: disp_reg=0x7FFF_FFFF, O=1, N=0.
- LDI R0,9 → done pulses; result=9; R0 still reads 0; ADD R5,R0,R0 → result 0, Z=1.
- Hold cmd_valid high with back-to-back commands → exactly one accept per 4 cycles; cmd_ready low in READ/EXEC/WB; commands applied in order.
- SHL R6,R1,R2 with R1=1, R2=35 → shift by 3 → result 8. SLT with R1=−1, R2=1 → result 1.
